// File: rtl/ctr_timeslot_arb.sv
// ctr_timeslot_arb: round-robin arbiter lending one down-counting interval timer to NumReq requesters.
// Defining CTR_TIMESLOT_ARB_ABORT_EN adds abort_i, which cancels a running interval without a done pulse.
module ctr_timeslot_arb #(
  parameter int NumReq = 4,
  parameter int Width  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
`ifdef CTR_TIMESLOT_ARB_ABORT_EN
  input  logic                    abort_i,
`endif
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq*Width-1:0] dur_i,
  output logic [NumReq-1:0]       gnt_o,
  output logic [NumReq-1:0]       done_o,
  output logic                    busy_o,
  output logic [Width-1:0]        cnt_o
);
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [Width-1:0] cnt, cnt_d;
  logic [IdxW-1:0] owner, owner_d, ptr, ptr_d, win;
  logic found, abort;
  logic [NumReq-1:0] owner_oh;
`ifdef CTR_TIMESLOT_ARB_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif
  // Round-robin search starts just past the last owner, so it has lowest priority next time.
  always_comb begin
    win = ptr;
    found = 1'b0;
    for (int i = 1; i <= NumReq; i++) begin
      if (!found && req_i[(int'(ptr) + i) % NumReq]) begin
        win = IdxW'((int'(ptr) + i) % NumReq);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= '0;
      ptr   <= IdxW'(NumReq - 1);
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      owner <= owner_d;
      ptr   <= ptr_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    owner_d = owner;
    ptr_d   = ptr;
    unique case (state)
      IDLE: if (found) begin
        owner_d = win;
        cnt_d   = dur_i[int'(win)*Width +: Width];
        state_d = RUN;
      end
      RUN: if (abort) begin
        state_d = IDLE;
        ptr_d   = owner;
        cnt_d   = '0;
      end else if (cnt == '0) state_d = DONE;
      else cnt_d = cnt - Width'(1);
      DONE: begin
        state_d = IDLE;
        ptr_d   = owner;
      end
      default: state_d = IDLE;
    endcase
  end
  assign owner_oh = NumReq'(1) << owner;
  always_comb begin
    gnt_o  = (state != IDLE) ? owner_oh : '0;
    done_o = (state == DONE) ? owner_oh : '0;
    busy_o = state != IDLE;
    cnt_o  = cnt;
  end
endmodule

// File: tb/tb_ctr_timeslot_arb.sv
// tb_ctr_timeslot_arb: directed plus random stimulus against a grant-lifetime reference model.
module tb_ctr_timeslot_arb;
  localparam int NR = 4;
  localparam int W  = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR*W-1:0] dur = '0;
  logic [NR-1:0] gnt, done;
  logic busy;
  logic [W-1:0] cnt;
  int checks = 0;
  int errors = 0;
  // Model: a grant of duration D lives D+2 cycles; m_left counts the cycles it still has.
  int m_left = 0;
  int m_owner = 0;
  int m_ptr = NR - 1;
  logic [NR-1:0] gq[$];
  logic [NR-1:0] gprev;

  always #5 clk = ~clk;

  ctr_timeslot_arb #(.NumReq(NR), .Width(W)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
`ifdef CTR_TIMESLOT_ARB_ABORT_EN
    .abort_i(abort),
`endif
    .req_i(req),
    .dur_i(dur),
    .gnt_o(gnt),
    .done_o(done),
    .busy_o(busy),
    .cnt_o(cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt();
    return (m_left >= 2) ? m_left - 2 : 0;
  endfunction

  task automatic check_all(input string tag);
    logic [NR-1:0] oh;
    oh = (m_left > 0) ? NR'(1) << m_owner : '0;
    chk({tag, ".gnt"}, 32'(gnt), 32'(oh));
    chk({tag, ".done"}, 32'(done), (m_left == 1) ? 32'(oh) : 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'(m_left > 0));
    chk({tag, ".cnt"}, 32'(cnt), 32'(exp_cnt()));
  endtask

  task automatic model_edge();
    if (m_left == 0) begin
      for (int i = 1; i <= NR; i++) begin
        int k = (m_ptr + i) % NR;
        if (req[k]) begin
          m_owner = k;
          m_left = int'(dur[k*W +: W]) + 2;
          break;
        end
      end
    end else if (abort && m_left >= 2) begin
      m_left = 0;
      m_ptr = m_owner;
    end else begin
      m_left--;
      if (m_left == 0) m_ptr = m_owner;
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_left = 0;
    m_owner = 0;
    m_ptr = NR - 1;
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    // single request, duration 3, request dropped after the grant edge
    req = 4'b0100;
    dur[2*W +: W] = 4'd3;
    step("t1_grant");
    chk("t1_gnt", 32'(gnt), 32'h4);
    chk("t1_cnt0", 32'(cnt), 32'd3);
    req = '0;
    for (int i = 0; i < 6; i++) step("t1_run");
    chk("t1_busy_end", 32'(busy), 32'd0);

    // all requesting, duration 1: order 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    dur = {4'd1, 4'd1, 4'd1, 4'd1};
    gprev = '0;
    gq.delete();
    for (int i = 0; i < 20; i++) begin
      step("t2_rr");
      if (gnt != '0 && gprev == '0) gq.push_back(gnt);
      gprev = gnt;
    end
    chk("t2_ngrants", 32'(gq.size()), 32'd5);
    if (gq.size() >= 5) begin
      chk("t2_ord0", 32'(gq[0]), 32'h1);
      chk("t2_ord1", 32'(gq[1]), 32'h2);
      chk("t2_ord2", 32'(gq[2]), 32'h4);
      chk("t2_ord3", 32'(gq[3]), 32'h8);
      chk("t2_ord4", 32'(gq[4]), 32'h1);
    end
    req = '0;
    for (int i = 0; i < 4; i++) step("t2_drain");

    // zero duration
    req = 4'b0001;
    dur[0 +: W] = 4'd0;
    step("t3_grant");
    req = '0;
    step("t3_done");
    chk("t3_done0", 32'(done), 32'h1);
    step("t3_idle");

    // reset mid-interval
    do_reset();
    req = 4'b0010;
    dur[1*W +: W] = 4'd15;
    step("t4_grant");
    for (int i = 0; i < 40 && exp_cnt() != 9; i++) step("t4_run");
    chk("t4_at9", 32'(cnt), 32'd9);
    #2;
    rst_n = 1'b0;
    m_left = 0;
    m_owner = 0;
    m_ptr = NR - 1;
    #1;
    check_all("t4_async");
    @(posedge clk);
    #1;
    check_all("t4_held");
    rst_n = 1'b1;
    req = 4'b0011;
    step("t4_regrant");
    chk("t4_gnt0", 32'(gnt), 32'h1);
    req = '0;
    for (int i = 0; i < 20 && m_left != 0; i++) step("t4_drain");

    // owner drops request and changes duration mid-interval
    do_reset();
    req = 4'b1000;
    dur[3*W +: W] = 4'd5;
    step("t5_grant");
    for (int i = 0; i < 20 && exp_cnt() != 4; i++) step("t5_run");
    req = '0;
    dur[3*W +: W] = 4'd0;
    for (int i = 0; i < 5; i++) step("t5_cont");
    chk("t5_done3", 32'(done), 32'h8);
    step("t5_idle");

`ifdef CTR_TIMESLOT_ARB_ABORT_EN
    do_reset();
    req = 4'b0100;
    dur[2*W +: W] = 4'd8;
    step("t6_grant");
    req = '0;
    for (int i = 0; i < 20 && exp_cnt() != 6; i++) step("t6_run");
    abort = 1'b1;
    step("t6_abort");
    chk("t6_gnt_off", 32'(gnt), 32'h0);
    abort = 1'b0;
    req = 4'b0101;
    step("t6_regrant");
    chk("t6_gnt0", 32'(gnt), 32'h1);
    req = '0;
    for (int i = 0; i < 20 && m_left != 0; i++) step("t6_drain");
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) req = NR'($urandom);
      if ($urandom_range(3) == 0) dur = (NR*W)'($urandom);
      if ($urandom_range(15) == 0) dur[0 +: W] = '1;
`ifdef CTR_TIMESLOT_ARB_ABORT_EN
      abort = ($urandom_range(15) == 0);
`endif
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
